// File: rtl/demux_pkg.sv
// demux_pkg: shared definitions for the registered 1-to-2 stream demultiplexer.
//   DEMUX_OUT0/DEMUX_OUT1 : select values for the two destinations
//   slot_state_e          : per-output holding-register state
//   CNT_W/CNT_MAX         : width and saturation value of the optional
//                           transfer counters (DEMUX1TO2_CNT_EN)
package demux_pkg;

  localparam logic DEMUX_OUT0 = 1'b0;
  localparam logic DEMUX_OUT1 = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam int              CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry output holding register with valid/ready handshake.
// Optional feature macro: DEMUX1TO2_CNT_EN (adds a saturating drain counter).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   load_i     write data_i into the slot this edge (accept routed here)
//   data_i     word to load
//   ready_i    consumer takes the held word
//   valid_o    slot is FULL
//   data_o     held word; changes only on a load
//   cnt_o      drains seen since reset, saturating (DEMUX1TO2_CNT_EN only)
//
// state      | meaning
// SLOT_EMPTY | no word held, valid_o low
// SLOT_FULL  | word held on data_o, valid_o high
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
`ifdef DEMUX1TO2_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_o
`endif
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             drain;

  assign drain = (state_q == SLOT_FULL) && ready_i;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    // A load wins over a drain: on a simultaneous drain and load the new
    // word replaces the one being taken and the slot stays FULL.
    if (load_i) begin
      state_d = SLOT_FULL;
      data_d  = data_i;
    end else if (drain) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = data_q;

`ifdef DEMUX1TO2_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (drain && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Reset takes priority, so a drain coinciding with reset is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/demux1to2_reg.sv
// demux1to2_reg: registered 1-to-2 stream demultiplexer. Each accepted word
// goes to out0 (in_sel=0) or out1 (in_sel=1); each output has its own
// one-entry slot so a stalled consumer never blocks the other.
// Optional feature macro: DEMUX1TO2_CNT_EN (per-output drain counters).
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_data, in_sel, in_valid         input word, destination, valid
//   in_ready                          word accepted this cycle (combinational)
//   out0_data, out0_valid, out0_ready consumer 0 handshake
//   out1_data, out1_valid, out1_ready consumer 1 handshake
//   cnt0, cnt1                        saturating drain counters (macro only)
module demux1to2_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX1TO2_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  logic accept;
  logic load0, load1;
  logic sel_room;

  // The selected slot can take a word if it is empty or is being drained
  // on this same edge.
  always_comb begin
    sel_room = 1'b0;
    if (in_sel == DEMUX_OUT1) begin
      sel_room = !out1_valid || out1_ready;
    end else begin
      sel_room = !out0_valid || out0_ready;
    end
  end

  assign in_ready = !rst && sel_room;
  assign accept   = in_valid && in_ready;
  assign load0    = accept && (in_sel == DEMUX_OUT0);
  assign load1    = accept && (in_sel == DEMUX_OUT1);

  demux_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load0),
    .data_i  (in_data),
    .ready_i (out0_ready),
    .valid_o (out0_valid),
    .data_o  (out0_data)
`ifdef DEMUX1TO2_CNT_EN
    ,
    .cnt_o   (cnt0)
`endif
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load1),
    .data_i  (in_data),
    .ready_i (out1_ready),
    .valid_o (out1_valid),
    .data_o  (out1_data)
`ifdef DEMUX1TO2_CNT_EN
    ,
    .cnt_o   (cnt1)
`endif
  );

endmodule

// File: tb/tb_demux1to2_reg.sv
module tb_demux1to2_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out0_data, out1_data;
  logic       out0_valid, out1_valid;
  logic       out0_ready, out1_ready;
`ifdef DEMUX1TO2_CNT_EN
  logic [7:0] cnt0, cnt1;
`endif

  demux1to2_reg #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
`ifdef DEMUX1TO2_CNT_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each output is a queue of words waiting for its consumer. A word
  // can only be accepted if its destination queue is empty or is being
  // drained this cycle. Delivered words are logged per output for ordering.
  logic [7:0] q0[$], q1[$], dlv0[$], dlv1[$];
  logic [7:0] md0 = 8'h00, md1 = 8'h00;
  int         mc0 = 0, mc1 = 0;

  function automatic bit m_ready();
    if (rst) return 1'b0;
    if (in_sel) return (q1.size() == 0) || out1_ready;
    return (q0.size() == 0) || out0_ready;
  endfunction

  always @(posedge clk) begin
    bit acc;
    acc = in_valid && m_ready();
    if (rst) begin
      q0.delete();
      q1.delete();
      md0 = 8'h00;
      md1 = 8'h00;
      mc0 = 0;
      mc1 = 0;
    end else begin
      if (q0.size() != 0 && out0_ready) begin
        dlv0.push_back(q0.pop_front());
        mc0 = (mc0 >= 255) ? 255 : mc0 + 1;
      end
      if (q1.size() != 0 && out1_ready) begin
        dlv1.push_back(q1.pop_front());
        mc1 = (mc1 >= 255) ? 255 : mc1 + 1;
      end
      if (acc) begin
        if (in_sel) begin
          q1.push_back(in_data);
          md1 = in_data;
        end else begin
          q0.push_back(in_data);
          md0 = in_data;
        end
      end
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready", int'(in_ready), int'(m_ready()));
      chk("out0_valid", int'(out0_valid), int'(q0.size() != 0));
      chk("out1_valid", int'(out1_valid), int'(q1.size() != 0));
      chk("out0_data", int'(out0_data), int'(md0));
      chk("out1_data", int'(out1_data), int'(md1));
`ifdef DEMUX1TO2_CNT_EN
      chk("cnt0", int'(cnt0), mc0);
      chk("cnt1", int'(cnt1), mc1);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_data = 8'h00; in_sel = 1'b0; in_valid = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    chk("rst_v0", int'(out0_valid), 0);
    chk("rst_v1", int'(out1_valid), 0);
    chk("rst_d0", int'(out0_data), 0);
    chk("rst_d1", int'(out1_data), 0);
    chk("rst_rdy", int'(in_ready), 0);
    rst = 1'b0;

    // Basic routing
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hA5;
    #1 chk("basic_rdy0", int'(in_ready), 1);
    tick();
    chk("basic_v0", int'(out0_valid), 1);
    chk("basic_d0", int'(out0_data), 8'hA5);
    in_sel = 1'b1; in_data = 8'h3C;
    #1 chk("basic_rdy1", int'(in_ready), 1);
    tick();
    chk("basic_v1", int'(out1_valid), 1);
    chk("basic_d1", int'(out1_data), 8'h3C);
    chk("basic_v0_gone", int'(out0_valid), 0);
    in_valid = 1'b0;
    tick();
    chk("basic_v1_gone", int'(out1_valid), 0);

    // Stall isolation
    out0_ready = 1'b0; out1_ready = 1'b1;
    dlv0.delete(); dlv1.delete();
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h11;
    tick();
    chk("stall_d0", int'(out0_data), 8'h11);
    in_sel = 1'b1; in_data = 8'h22;
    tick();
    chk("stall_d1", int'(out1_data), 8'h22);
    chk("stall_v1", int'(out1_valid), 1);
    chk("stall_hold0", int'(out0_data), 8'h11);
    in_sel = 1'b0; in_data = 8'h33;
    #1 chk("stall_blocked", int'(in_ready), 0);
    tick();
    chk("stall_still11", int'(out0_data), 8'h11);
    chk("stall_v0", int'(out0_valid), 1);
    out0_ready = 1'b1;
    #1 chk("stall_unblocked", int'(in_ready), 1);
    tick();
    chk("stall_d0_33", int'(out0_data), 8'h33);
    chk("stall_dlv0_11", (dlv0.size() == 1) ? int'(dlv0[0]) : -1, 8'h11);
    in_valid = 1'b0;
    tick();
    chk("stall_dlv0_33", (dlv0.size() == 2) ? int'(dlv0[1]) : -1, 8'h33);
    chk("stall_dlv1_22", (dlv1.size() == 1) ? int'(dlv1[0]) : -1, 8'h22);

    // Full-rate stream to out1
    dlv1.delete();
    out1_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_sel = 1'b1; in_data = 8'(i);
      #1 chk("rate_rdy", int'(in_ready), 1);
      tick();
      chk("rate_d1", int'(out1_data), i);
    end
    in_valid = 1'b0;
    tick();
    chk("rate_count", dlv1.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk("rate_order", (i < dlv1.size()) ? int'(dlv1[i]) : -1, i);
    end

    // Reset mid-operation
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h55;
    tick();
    in_sel = 1'b1; in_data = 8'hAA;
    tick();
    chk("mid_v0", int'(out0_valid), 1);
    chk("mid_v1", int'(out1_valid), 1);
    in_valid = 1'b0;
    dlv0.delete(); dlv1.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_v0", int'(out0_valid), 0);
    chk("mid_rst_v1", int'(out1_valid), 0);
    chk("mid_rst_d0", int'(out0_data), 0);
    chk("mid_rst_d1", int'(out1_data), 0);
    out0_ready = 1'b1; out1_ready = 1'b1;
    tick();
    tick();
    chk("mid_no_dlv0", dlv0.size(), 0);
    chk("mid_no_dlv1", dlv1.size(), 0);

    // Drain 300 words on out0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dlv0.delete(); dlv1.delete();
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; in_sel = 1'b0; in_data = 8'(i + 7);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("sat_dlv0", dlv0.size(), 300);
    chk("sat_dlv1", dlv1.size(), 0);
    chk("sat_last", (dlv0.size() == 300) ? int'(dlv0[299]) : -1, 8'((299 + 7) % 256));
`ifdef DEMUX1TO2_CNT_EN
    chk("sat_cnt0", int'(cnt0), 255);
    chk("sat_cnt1", int'(cnt1), 0);
`endif

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/demux1to2_reg.md
# demux1to2_reg

Registered 1-to-2 stream demultiplexer: routes each accepted input word to output 0 or output 1 according to a per-word select bit. It is the counterpart of the team's 2-to-1 multiplexers and sits wherever one producer must feed two independent consumers. Each output owns a one-entry holding register with a valid/ready handshake, so a stalled consumer never blocks traffic to the other output.

## Interface
- WIDTH, 8, data word width in bits
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  input word
- in_sel  input  1  destination of the current word: 0 routes to out0, 1 routes to out1
- in_valid  input  1  in_data and in_sel are valid
- in_ready  output  1  block accepts the word this cycle
- out0_data  output  WIDTH  held word for consumer 0
- out0_valid  output  1  out0_data is valid
- out0_ready  input  1  consumer 0 takes the word
- out1_data, out1_valid, out1_ready: same as the port-0 signals, for consumer 1
- cnt0, cnt1  output  8  per-output transfer counters; present only with DEMUX1TO2_CNT_EN

## Operation
- Each output slot is a two-state machine, EMPTY or FULL; outN_valid = (slot N is FULL).
- in_ready = !full[in_sel] | outN_ready, where N = in_sel. This path is combinational from in_sel and the selected outN_ready.
- Accept: in_valid & in_ready.
- Drain N: outN_valid & outN_ready.
- Slot N transitions:
  - EMPTY -> FULL on accept with in_sel = N.
  - FULL -> EMPTY on drain N with no accept to N.
  - FULL -> FULL on simultaneous drain N and accept to N; the new word replaces the old one.
- The non-selected slot is never written by an accept; it only drains.
- outN_data changes only when slot N loads a word. It stays stable while outN_valid & !outN_ready.
- The block does not reorder words for a given output. Words sent to different outputs have no ordering relation.
- When in_valid = 0, in_sel and in_data are ignored.

## Timing
- Latency: a word accepted at edge k is visible on outN_data/outN_valid after edge k; the consumer can take it at edge k+1.
- Throughput: 1 word/cycle per output while that consumer holds ready high.
- Reset (rst high at an edge): both slots go EMPTY; out0_valid = out1_valid = 0; out0_data = out1_data = 0; cnt0 = cnt1 = 0.
- Reset mid-operation: held words are discarded, and no drain is counted on the reset edge.
- in_ready is 0 while rst is high.

## Configuration
- DEMUX1TO2_CNT_EN defined:
  - cnt0 and cnt1 exist. Each increments by 1 on every drain of its output.
  - Each saturates at 255 and holds there; it does not wrap.
  - Both clear only on rst.
- DEMUX1TO2_CNT_EN undefined: the cnt0/cnt1 ports and the counter logic are absent. All other behaviour is identical.

## Structure
- Package demux_pkg:
  - constants DEMUX_OUT0 = 1'b0 and DEMUX_OUT1 = 1'b1;
  - slot state encoding SLOT_EMPTY and SLOT_FULL;
  - counter width CNT_W = 8 and CNT_MAX = 8'hFF.
- Sub-module demux_slot, instantiated twice. It holds one output register: the full flag, the data register, load/drain logic, and the optional counter. The top level does only the select decode and the in_ready mux.

## Test plan
- Basic routing: rst for 2 cycles, both consumers ready; send 8'hA5 with sel=0, then 8'h3C with sel=1 -> out0_data=8'hA5 with out0_valid for one cycle; next cycle out1_data=8'h3C with out1_valid; in_ready stays 1 throughout.
- Stall isolation: out0_ready=0, out1_ready=1; send 8'h11 to out0, 8'h22 to out1, 8'h33 to out0 ->
  - 8'h11 is held on out0 with out0_data stable;
  - 8'h22 delivered on out1;
  - in_ready=0 while 8'h33 is presented with sel=0;
  - raising out0_ready drains 8'h11 and accepts 8'h33 on the same edge.
- Full-rate replace: out1_ready=1 continuously; stream 8'h00..8'h0F with sel=1 back to back -> 16 words on out1 in order, one per cycle, and in_ready never drops.
- Reset mid-operation: both slots FULL with 8'h55/8'hAA and ready=0; assert rst for one cycle -> both valids 0 and both data 0 after the edge; neither word ever appears at a consumer.
- Counter saturation (DEMUX1TO2_CNT_EN): drain 300 words on out0 -> cnt0 = 255, cnt1 = 0. Rebuild without the macro -> the same stimulus passes the routing checks.
